// File: rtl/byte_entry_encoder_pkg.sv
// rtl/byte_entry_encoder_pkg.sv - shared state encoding, BCD limit and result width
package byte_entry_encoder_pkg;

    typedef enum logic [2:0] {
        ST_EMPTY = 3'd0,
        ST_ONE   = 3'd1,
        ST_TWO   = 3'd2,
        ST_CONV  = 3'd3,
        ST_HOLD  = 3'd4
    } state_t;

    localparam logic [3:0] BCD_MAX  = 4'd9;
    localparam int         RESULT_W = 8;

    // tens*10 + ones using shifts: (t<<3)+(t<<1)+o, fits 7 bits for 0..99
    function automatic logic [6:0] bcd_mag(input logic [3:0] tens, input logic [3:0] ones);
        logic [6:0] t;
        t = {3'b000, tens};
        return (t << 3) + (t << 1) + {3'b000, ones};
    endfunction

endpackage

// File: rtl/byte_entry_encoder_btn_sync_edge.sv
// rtl/byte_entry_encoder_btn_sync_edge.sv - raw button synchronizer plus rising-edge strobe
module btn_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic ar,
    input  logic btn_raw,
    output logic strobe
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   prev_q;
    logic                   prev_d;

    // shift the raw level through the chain and remember the last synchronized level
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], btn_raw};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    // synchronizer and edge-detect flops, cleared asynchronously
    always_ff @(posedge clk or negedge ar) begin
        if (!ar) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    // a held button yields a single strobe; it must drop low before striking again
    assign strobe = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/byte_entry_encoder.sv
// rtl/byte_entry_encoder.sv - collects two BCD digits and a sign, encodes a signed byte
module byte_entry_encoder
    import byte_entry_encoder_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                ar,
    input  logic [3:0]          digit,
    input  logic                dig_btn,
    input  logic                neg_btn,
    input  logic                enter_btn,
    input  logic                clr_btn,
    input  logic                out_ready,
    output logic [RESULT_W-1:0] num,
    output logic                out_valid,
    output logic                busy,
    output logic                err,
    output logic [3:0]          d0,
    output logic [3:0]          d1,
    output logic                sign
);

    logic dig_stb;
    logic neg_stb;
    logic ent_stb;
    logic clr_stb;

    btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_dig (.clk(clk), .ar(ar), .btn_raw(dig_btn),   .strobe(dig_stb));
    btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_neg (.clk(clk), .ar(ar), .btn_raw(neg_btn),   .strobe(neg_stb));
    btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_ent (.clk(clk), .ar(ar), .btn_raw(enter_btn), .strobe(ent_stb));
    btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_clr (.clk(clk), .ar(ar), .btn_raw(clr_btn),   .strobe(clr_stb));

    state_t              state_q, state_d;
    logic [3:0]          d0_q, d0_d;
    logic [3:0]          d1_q, d1_d;
    logic                sign_q, sign_d;
    logic [RESULT_W-1:0] num_q, num_d;
    logic                out_valid_q, out_valid_d;
    logic                busy_q, busy_d;
    logic                err_q, err_d;

    logic [6:0]          mag;
    logic [RESULT_W-1:0] mag_ext;

    assign mag     = bcd_mag(d1_q, d0_q);
    assign mag_ext = {1'b0, mag};

    // next-state: strobes act only while entering, highest priority clr > enter > digit > neg
    always_comb begin
        state_d     = state_q;
        d0_d        = d0_q;
        d1_d        = d1_q;
        sign_d      = sign_q;
        num_d       = num_q;
        err_d       = 1'b0;
        case (state_q)
            ST_EMPTY, ST_ONE, ST_TWO: begin
                if (clr_stb) begin
                    d0_d    = 4'd0;
                    d1_d    = 4'd0;
                    sign_d  = 1'b0;
                    state_d = ST_EMPTY;
                end else if (ent_stb) begin
                    state_d = ST_CONV;
                end else if (dig_stb) begin
                    if (digit <= BCD_MAX) begin
                        d1_d    = d0_q;
                        d0_d    = digit;
                        state_d = (state_q == ST_EMPTY) ? ST_ONE : ST_TWO;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (neg_stb) begin
                    sign_d = ~sign_q;
                end
            end
            ST_CONV: begin
                // a zero magnitude ignores the sign so -0 encodes as 0x00
                if (sign_q && (mag != 7'd0)) begin
                    num_d = ~mag_ext + 8'd1;
                end else begin
                    num_d = mag_ext;
                end
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (out_valid_q && out_ready) begin
                    d0_d    = 4'd0;
                    d1_d    = 4'd0;
                    sign_d  = 1'b0;
                    state_d = ST_EMPTY;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
        busy_d      = (state_d == ST_CONV) || (state_d == ST_HOLD);
        out_valid_d = (state_d == ST_HOLD);
    end

    // state, digit echoes and registered outputs
    always_ff @(posedge clk or negedge ar) begin
        if (!ar) begin
            state_q     <= ST_EMPTY;
            d0_q        <= 4'd0;
            d1_q        <= 4'd0;
            sign_q      <= 1'b0;
            num_q       <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            d0_q        <= d0_d;
            d1_q        <= d1_d;
            sign_q      <= sign_d;
            num_q       <= num_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
        end
    end

    assign num       = num_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign err       = err_q;
    assign d0        = d0_q;
    assign d1        = d1_q;
    assign sign      = sign_q;

endmodule

// File: tb/tb_byte_entry_encoder.sv
// tb/tb_byte_entry_encoder.sv - scoreboard bench with randomized entries and reference model
module tb_byte_entry_encoder;

    localparam int S = 2;

    logic       clk = 1'b0;
    logic       ar = 1'b0;
    logic [3:0] digit = 4'd0;
    logic       dig_btn = 1'b0;
    logic       neg_btn = 1'b0;
    logic       enter_btn = 1'b0;
    logic       clr_btn = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] num;
    logic       out_valid;
    logic       busy;
    logic       err;
    logic [3:0] d0;
    logic [3:0] d1;
    logic       sign;

    byte_entry_encoder #(.SYNC_STAGES(S)) dut (
        .clk(clk), .ar(ar), .digit(digit), .dig_btn(dig_btn), .neg_btn(neg_btn),
        .enter_btn(enter_btn), .clr_btn(clr_btn), .out_ready(out_ready),
        .num(num), .out_valid(out_valid), .busy(busy), .err(err),
        .d0(d0), .d1(d1), .sign(sign)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int exp_q[$];
    int ov_cycles = 0;
    int first_ov_cyc = -1;
    bit ov_prev = 1'b0;
    int err_seen = 0;
    int err_exp = 0;
    int press_cyc = 0;

    int m_d0 = 0;
    int m_d1 = 0;
    bit m_sign = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // monitor: count valid/err cycles and score every transfer against the queue
    always @(negedge clk) begin
        if (ar) begin
            if (err) err_seen++;
            if (out_valid) begin
                ov_cycles++;
                if (!ov_prev) first_ov_cyc = cyc;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("transfer_with_empty_queue", exp_q.size(), 1);
                else check("scoreboard_num", num, exp_q.pop_front());
            end
        end
        ov_prev = out_valid;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // mask bits: 0 digit, 1 neg, 2 enter, 3 clr
    task automatic press(input bit [3:0] mask, input logic [3:0] dv);
        tick;
        digit = dv;
        dig_btn = mask[0];
        neg_btn = mask[1];
        enter_btn = mask[2];
        clr_btn = mask[3];
        press_cyc = cyc;
        tick;
        dig_btn = 1'b0;
        neg_btn = 1'b0;
        enter_btn = 1'b0;
        clr_btn = 1'b0;
        repeat (S + 1) tick;
    endtask

    function automatic int m_value();
        int mag;
        mag = m_d1 * 10 + m_d0;
        if (m_sign && mag != 0) return 256 - mag;
        return mag;
    endfunction

    task automatic m_clear;
        m_d0 = 0;
        m_d1 = 0;
        m_sign = 1'b0;
    endtask

    task automatic do_digit(input int v);
        logic [3:0] dv;
        dv = v[3:0];
        press(4'b0001, dv);
        if (v <= 9) begin
            m_d1 = m_d0;
            m_d0 = v;
        end else begin
            err_exp++;
        end
        @(negedge clk);
        check("echo_d0", d0, m_d0);
        check("echo_d1", d1, m_d1);
    endtask

    task automatic do_neg;
        press(4'b0010, 4'd0);
        m_sign = ~m_sign;
        @(negedge clk);
        check("echo_sign", sign, m_sign);
    endtask

    task automatic do_enter;
        exp_q.push_back(m_value());
        press(4'b0100, 4'd0);
        m_clear();
    endtask

    task automatic wait_ov(input bit lvl, input string name);
        int n;
        n = 0;
        while (out_valid !== lvl && n < 50) begin
            @(negedge clk);
            n++;
        end
        check(name, out_valid, lvl);
    endtask

    initial begin
        int ov_base;
        int pc;
        int err_base;
        int n;
        int v;

        repeat (3) @(negedge clk);
        check("reset_num", num, 0);
        check("reset_out_valid", out_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_err", err, 0);
        check("reset_d0", d0, 0);
        check("reset_d1", d1, 0);
        check("reset_sign", sign, 0);
        tick;
        ar = 1'b1;

        // reset while a result is being offered
        out_ready = 1'b0;
        do_digit(4);
        do_digit(2);
        do_enter();
        wait_ov(1'b1, "abort_hold_reached");
        ar = 1'b0;
        #1;
        check("abort_num", num, 0);
        check("abort_out_valid", out_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_d0", d0, 0);
        check("abort_d1", d1, 0);
        exp_q.delete();
        m_clear();
        tick;
        ar = 1'b1;
        do_digit(7);
        press(4'b1000, 4'd0);
        m_clear();
        @(negedge clk);
        check("clr_d0", d0, 0);

        // positive entry, consumer always ready
        out_ready = 1'b1;
        do_digit(4);
        do_digit(2);
        ov_base = ov_cycles;
        do_enter();
        pc = press_cyc;
        repeat (4) tick;
        @(negedge clk);
        check("pos_ov_cycles", ov_cycles - ov_base, 1);
        check("pos_latency", first_ov_cyc - pc, S + 2);
        check("pos_d0_cleared", d0, 0);
        check("pos_d1_cleared", d1, 0);
        check("pos_busy_low", busy, 0);
        check("pos_num_retained", num, 8'h2A);

        // negative entry with stalled consumer
        out_ready = 1'b0;
        do_digit(9);
        do_digit(9);
        do_neg();
        do_enter();
        wait_ov(1'b1, "neg_valid_rise");
        for (int i = 0; i < 5; i++) begin
            check("neg_hold_valid", out_valid, 1);
            check("neg_hold_num", num, 8'h9D);
            @(negedge clk);
        end
        tick;
        out_ready = 1'b1;
        wait_ov(1'b0, "neg_transfer");

        // shift through three digits, then a rejected digit
        do_digit(1);
        do_digit(2);
        do_digit(3);
        err_base = err_seen;
        do_digit(12);
        repeat (2) tick;
        check("reject_err_pulse", err_seen - err_base, 1);
        do_enter();
        wait_ov(1'b1, "shift_valid");
        wait_ov(1'b0, "shift_transfer");

        // sign with no digits encodes zero
        do_neg();
        do_enter();
        wait_ov(1'b1, "neg_zero_valid");
        wait_ov(1'b0, "neg_zero_transfer");

        // clr beats enter
        do_digit(5);
        ov_base = ov_cycles;
        press(4'b1100, 4'd0);
        m_clear();
        @(negedge clk);
        check("clr_enter_busy", busy, 0);
        check("clr_enter_d0", d0, 0);
        repeat (3) tick;
        check("clr_enter_no_valid", ov_cycles - ov_base, 0);

        // buttons during HOLD are discarded
        out_ready = 1'b0;
        do_digit(6);
        do_digit(1);
        do_enter();
        wait_ov(1'b1, "hold_ign_valid");
        press(4'b0001, 4'd3);
        press(4'b0010, 4'd0);
        press(4'b1000, 4'd0);
        press(4'b0100, 4'd0);
        @(negedge clk);
        check("hold_ign_d0", d0, 1);
        check("hold_ign_d1", d1, 6);
        check("hold_ign_sign", sign, 0);
        check("hold_ign_valid_still", out_valid, 1);
        check("hold_ign_num", num, 61);
        tick;
        out_ready = 1'b1;
        wait_ov(1'b0, "hold_ign_transfer");
        repeat (4) tick;
        check("hold_ign_idle", busy, 0);

        // randomized entries
        for (int r = 0; r < 30; r++) begin
            tick;
            out_ready = 1'b0;
            n = $urandom_range(0, 4);
            for (int k = 0; k < n; k++) begin
                if ($urandom_range(0, 3) == 0) do_neg();
                else begin
                    v = $urandom_range(0, 15);
                    do_digit(v);
                end
            end
            do_enter();
            wait_ov(1'b1, "rand_valid");
            repeat ($urandom_range(0, 3)) tick;
            tick;
            out_ready = 1'b1;
            wait_ov(1'b0, "rand_transfer");
            @(negedge clk);
            check("rand_clear_d0", d0, 0);
            check("rand_clear_sign", sign, 0);
        end

        repeat (3) tick;
        check("queue_drained", exp_q.size(), 0);
        check("err_pulse_total", err_seen, err_exp);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/byte_entry_encoder.md
# byte_entry_encoder

Input-side counterpart of the result display path. The display path turns a signed byte into two decimal digits plus a sign. This block does the reverse: it collects two BCD digits and a sign from front-panel controls and encodes them into a signed 8-bit two's-complement operand. It holds that operand under a valid/ready handshake for the downstream consumer. It also echoes the digits being entered, so the existing seven-segment decoders can show them.

## Interface
Parameters:
- SYNC_STAGES, 2, synchronizer flops per raw control input (minimum 2)

Ports:
- clk  input  1  system clock
- ar  input  1  asynchronous, active-low reset
- digit  input  4  BCD value on switches; sampled when dig_btn fires
- dig_btn  input  1  raw button: push digit
- neg_btn  input  1  raw button: toggle sign
- enter_btn  input  1  raw button: encode and present
- clr_btn  input  1  raw button: discard entry
- out_ready  input  1  consumer accepts num this cycle
- num  output  8  signed two's-complement result, range −99..+99
- out_valid  output  1  num is stable and offered
- busy  output  1  high in CONV and HOLD
- err  output  1  one-cycle pulse on a rejected digit
- d0  output  4  ones digit echo
- d1  output  4  tens digit echo
- sign  output  1  sign echo, 1 = negative

## Operation
- Each raw button passes through a SYNC_STAGES flop synchronizer and then a rising-edge detector. The result is a one-cycle internal strobe. The `digit` bus is sampled on the same cycle as the dig_btn strobe.
- States:
  - EMPTY: no digits held.
  - ONE: one digit held.
  - TWO: two digits held.
  - CONV: computing.
  - HOLD: offering the result.
- Strobe priority when several fire together: clr > enter > digit > neg.
- clr, from any state except CONV/HOLD: d0 = d1 = 0, sign = 0, go to EMPTY.
- Digit strobe with digit ≤ 9:
  - EMPTY → ONE with d0 = digit.
  - ONE → TWO with d1 = d0, d0 = digit.
  - TWO stays TWO, same shift; the oldest digit is dropped.
- Digit strobe with digit > 9: ignored, state unchanged, err = 1 for one cycle.
- neg strobe: toggles sign in EMPTY, ONE and TWO.
- enter in EMPTY, ONE or TWO → CONV.
- CONV, exactly one cycle: mag = (d1<<3)+(d1<<1)+d0, 7-bit unsigned. If mag = 0, sign is treated as 0, so −0 encodes as 0x00.
- Leaving CONV: num = sign ? (~mag+1) : mag, sign-extended to 8 bits; go to HOLD.
- HOLD: out_valid = 1 and num is stable. At a clock edge where out_valid and out_ready are both 1, the result transfers. The block then returns to EMPTY, clears d0, d1 and sign, and drops out_valid.
- Every button strobe arriving in CONV or HOLD is discarded, including clr. Strobes are not queued.
- num keeps its last value after HOLD until the next CONV exit.

## Timing
- Reset (ar = 0, asynchronous): state EMPTY; num = 0x00; out_valid = 0; busy = 0; err = 0; d0 = d1 = 0; sign = 0; synchronizer and edge flops = 0.
- Button latency: raw input first sampled high at edge k. The strobe is internally high after edge k+SYNC_STAGES−1 and takes effect at edge k+SYNC_STAGES.
- A button held high produces exactly one strobe. It must go low for at least one sampled cycle before it can strike again.
- enter takes effect at edge e. Then busy = 1 from e, and out_valid = 1 with num valid from e+1.
- Minimum turnaround: out_ready tied high gives one HOLD cycle. busy falls at e+2, and a new entry strobe is accepted at the edge after that.
- The d0/d1/sign echoes update at the same edge as the strobe that changes them.
- err is high for exactly the cycle following the edge where the bad digit was rejected.
- Reset asserted in CONV or HOLD aborts the result immediately. No partial output remains.

## Structure
- Shared package holds:
  - the state encoding constants EMPTY/ONE/TWO/CONV/HOLD (3-bit);
  - BCD_MAX = 9;
  - the 8-bit result width, also used by the ALU operand path.
- One sub-module, `btn_sync_edge`: parameterized synchronizer plus rising-edge detector, instantiated four times.
- The FSM, digit registers and converter stay in the top block.

## Test plan
- Reset mid-HOLD: digits 4, 2 entered, enter, then ar low while out_valid = 1 → all outputs zero immediately; after release, state EMPTY.
- Positive entry: digits 4, 2, enter, out_ready = 1 → num = 0x2A; out_valid high exactly one cycle, one cycle after the enter strobe; then d0 = d1 = 0.
- Negative entry: digits 9, 9, neg, enter, out_ready held 0 for 5 cycles → num = 0x9D (−99) held stable with out_valid = 1 for 5 cycles; then transfers when out_ready rises.
- Shift and reject:
  - digits 1, 2, 3 → d1 = 2, d0 = 3;
  - digit 0xC → err one-cycle pulse, d1 and d0 unchanged;
  - enter → num = 0x17.
- Edge cases:
  - neg then enter with no digits → num = 0x00;
  - clr and enter together after digit 5 → state EMPTY, no out_valid;
  - buttons pressed during HOLD → ignored.
